axi_lite_arbiter: RTL and testbench
===================================

AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 Parameters SHALL be ADDR_W = 32 (address width) and DATA_W = 64 (data width); strobe width SHALL be DATA_W/8.
REQ-002 clk  in  1  sole clock; all logic on the rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 ifu_araddr/ifu_arvalid in ADDR_W/1; ifu_arready out 1  IFU read-address channel.
REQ-005 ifu_rdata/ifu_rresp/ifu_rvalid out DATA_W/2/1; ifu_rready in 1  IFU read-data channel.
REQ-006 lsu_araddr/lsu_arvalid in ADDR_W/1; lsu_arready out 1  LSU read-address channel.
REQ-007 lsu_rdata/lsu_rresp/lsu_rvalid out DATA_W/2/1; lsu_rready in 1  LSU read-data channel.
REQ-008 lsu_awaddr/lsu_awvalid in ADDR_W/1; lsu_awready out 1  LSU write-address channel.
REQ-009 lsu_wdata/lsu_wstrb/lsu_wvalid in DATA_W/8/1; lsu_wready out 1  LSU write-data channel.
REQ-010 lsu_bresp/lsu_bvalid out 2/1; lsu_bready in 1  LSU write-response channel.
REQ-011 m_ar*, m_r*, m_aw*, m_w*, m_b*: the same five channels toward the single AXI-lite slave, with directions mirrored.

Function
REQ-012 Exactly one transaction SHALL be outstanding on the m_* port at any time.
REQ-013 States SHALL be IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R, LSU_WR, LSU_B.
REQ-014 Transitions out of IDLE SHALL be evaluated on registered state with fixed priority lsu_awvalid|lsu_wvalid > lsu_arvalid > ifu_arvalid:
- LSU write -> LSU_WR
- LSU read -> LSU_AR
- IFU read -> IFU_AR
- no request -> remain in IDLE.
REQ-015 Grant latency SHALL be 1 cycle: a request first seen in IDLE is forwarded to m_* in the following state, never in IDLE itself.
REQ-016 In xx_AR, the owner's araddr/arvalid SHALL drive m_araddr/m_arvalid, and m_arready SHALL be returned to the owner; m_arvalid & m_arready moves the FSM to xx_R.
REQ-017 In xx_R:
- m_rdata/m_rresp/m_rvalid SHALL route to the owner only.
- The owner's rready SHALL drive m_rready.
- m_rvalid & m_rready moves the FSM to IDLE.
REQ-018 In LSU_WR:
- AW and W SHALL be forwarded independently.
- Registered flags aw_done and w_done SHALL record each handshake.
- The FSM moves to LSU_B when both are done; handshakes may occur in either order or in the same cycle.
- A channel already done SHALL see m_awvalid=0 or m_wvalid=0 respectively.
REQ-019 In LSU_B, m_bresp/m_bvalid SHALL route to the LSU and lsu_bready SHALL drive m_bready; the handshake moves the FSM to IDLE and clears aw_done and w_done.
REQ-020 A non-owner SHALL see all of its ready and valid outputs at 0; its data outputs SHALL be don't-care.
REQ-021 rresp and bresp SHALL pass through unmodified (SLVERR/DECERR are not interpreted).
REQ-022 All valid/ready outputs SHALL be combinational from state plus the paired input; there SHALL be no combinational path from m_* inputs to m_* outputs.
REQ-023 m_rvalid or m_bvalid arriving in a state that does not expect it SHALL be ignored (m_rready=0, m_bready=0).
REQ-024 Requesters holding valid while not granted SHALL stall indefinitely; the IFU is starved while the LSU requests back-to-back (accepted behaviour).

Reset
REQ-025 While rst=1:
- state SHALL be IDLE and aw_done=w_done=0.
- All m_*valid, m_rready and m_bready SHALL be 0.
- All requester ready and valid outputs SHALL be 0.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction at the next edge with no completion signalled; the slave is reset by the same rst.

Structure
REQ-027 The state encoding (3 bits), the RESP_OKAY/EXOKAY/SLVERR/DECERR constants and the width defaults SHALL reside in shared package axi_pkg.
REQ-028 No sub-module SHALL be required; the FSM and channel muxes SHALL be coded inline in approximately 150-250 lines.

Verification
REQ-029 IFU read only:
- Stimulus: ifu_araddr=0x8000_0000; slave returns rdata=0x1122334455667788 with arready and rvalid 1 cycle each.
- Response: ifu_rdata matches; FSM back in IDLE after 4 cycles; LSU outputs stay 0.
REQ-030 Simultaneous IFU and LSU reads:
- Stimulus: lsu_araddr=0x8000_1000 and ifu_araddr=0x8000_0004 raised in the same cycle.
- Response: LSU is served first; the IFU AR handshake occurs no earlier than 1 cycle after the LSU R handshake.
REQ-031 LSU write, W before AW:
- Stimulus: slave asserts wready 2 cycles before awready; wdata=0xDEAD_BEEF, wstrb=0x0F.
- Response: m_wvalid drops after the W handshake; bresp=OKAY is delivered to the LSU; FSM returns to IDLE.
REQ-032 Write and read pending together:
- Stimulus: lsu_awvalid, lsu_wvalid and lsu_arvalid all asserted.
- Response: the write completes through the B handshake before m_arvalid rises.
REQ-033 Reset mid-operation:
- Stimulus: rst asserted in IFU_R while the slave holds rvalid=0.
- Response: next cycle state=IDLE and all valid/ready outputs are 0.
- Follow-up: a new IFU read then completes normally.
REQ-034 Error passthrough:
- Stimulus: slave returns rresp=2'b10.
- Response: ifu_rresp=2'b10 is delivered unchanged.

Source files
------------

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI-lite widths, response codes and arbiter state encoding
package axi_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IFU_AR = 3'd1,
    ST_IFU_R  = 3'd2,
    ST_LSU_AR = 3'd3,
    ST_LSU_R  = 3'd4,
    ST_LSU_WR = 3'd5,
    ST_LSU_B  = 3'd6
  } state_t;

endpackage

// File: rtl/axi_lite_arbiter_if.sv
// rtl/axi_lite_arbiter_if.sv - five-channel AXI-lite bundle; rd_slave exposes only AR/R for read-only requesters
interface axi_lite_arbiter_if #(
  parameter int ADDR_W = axi_pkg::ADDR_W,
  parameter int DATA_W = axi_pkg::DATA_W
);

  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );

  modport rd_slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi_lite_arbiter.sv
// rtl/axi_lite_arbiter.sv - single-outstanding arbiter: LSU write > LSU read > IFU read onto one AXI-lite slave
module axi_lite_arbiter
  import axi_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  axi_lite_arbiter_if.rd_slave ifu,
  axi_lite_arbiter_if.slave    lsu,
  axi_lite_arbiter_if.master   m
);

  state_t state;
  state_t cur;
  logic   aw_done;
  logic   w_done;
  logic   aw_hs;
  logic   w_hs;

  // Outputs are forced idle for the whole time rst is high, not just after the first edge.
  assign cur   = rst ? ST_IDLE : state;
  assign aw_hs = m.awvalid && m.awready;
  assign w_hs  = m.wvalid && m.wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lsu.awvalid || lsu.wvalid) state <= ST_LSU_WR;
          else if (lsu.arvalid)          state <= ST_LSU_AR;
          else if (ifu.arvalid)          state <= ST_IFU_AR;
        end
        ST_IFU_AR: if (ifu.arvalid && m.arready) state <= ST_IFU_R;
        ST_IFU_R:  if (m.rvalid && ifu.rready)   state <= ST_IDLE;
        ST_LSU_AR: if (lsu.arvalid && m.arready) state <= ST_LSU_R;
        ST_LSU_R:  if (m.rvalid && lsu.rready)   state <= ST_IDLE;
        ST_LSU_WR: begin
          aw_done <= aw_done || aw_hs;
          w_done  <= w_done || w_hs;
          if ((aw_done || aw_hs) && (w_done || w_hs)) state <= ST_LSU_B;
        end
        ST_LSU_B: begin
          if (m.bvalid && lsu.bready) begin
            state   <= ST_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    m.araddr    = (cur == ST_LSU_AR) ? lsu.araddr : ifu.araddr;
    m.awaddr    = lsu.awaddr;
    m.wdata     = lsu.wdata;
    m.wstrb     = lsu.wstrb;
    ifu.rdata   = m.rdata;
    ifu.rresp   = m.rresp;
    lsu.rdata   = m.rdata;
    lsu.rresp   = m.rresp;
    lsu.bresp   = m.bresp;
    m.arvalid   = 1'b0;
    m.rready    = 1'b0;
    m.awvalid   = 1'b0;
    m.wvalid    = 1'b0;
    m.bready    = 1'b0;
    ifu.arready = 1'b0;
    ifu.rvalid  = 1'b0;
    lsu.arready = 1'b0;
    lsu.rvalid  = 1'b0;
    lsu.awready = 1'b0;
    lsu.wready  = 1'b0;
    lsu.bvalid  = 1'b0;
    case (cur)
      ST_IFU_AR: begin
        m.arvalid   = ifu.arvalid;
        ifu.arready = m.arready;
      end
      ST_IFU_R: begin
        m.rready   = ifu.rready;
        ifu.rvalid = m.rvalid;
      end
      ST_LSU_AR: begin
        m.arvalid   = lsu.arvalid;
        lsu.arready = m.arready;
      end
      ST_LSU_R: begin
        m.rready   = lsu.rready;
        lsu.rvalid = m.rvalid;
      end
      ST_LSU_WR: begin
        // A channel that already handshook is masked so the slave never sees a second beat.
        m.awvalid   = lsu.awvalid && !aw_done;
        lsu.awready = m.awready && !aw_done;
        m.wvalid    = lsu.wvalid && !w_done;
        lsu.wready  = m.wready && !w_done;
      end
      ST_LSU_B: begin
        m.bready   = lsu.bready;
        lsu.bvalid = m.bvalid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb/tb_axi_lite_arbiter.sv - directed and randomized checks of axi_lite_arbiter against a transaction-level model
module tb_axi_lite_arbiter;
  import axi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_lite_arbiter_if ifu_bus ();
  axi_lite_arbiter_if lsu_bus ();
  axi_lite_arbiter_if m_bus ();

  axi_lite_arbiter dut (.clk(clk), .rst(rst), .ifu(ifu_bus), .lsu(lsu_bus), .m(m_bus));

  typedef enum {OWN_NONE, OWN_IFU, OWN_LSU_RD, OWN_LSU_WR} own_t;

  int n_chk = 0, n_err = 0, cyc = 0, n_done = 0;
  own_t own = OWN_NONE;
  bit ar_done = 0, aw_done_m = 0, w_done_m = 0, s_rvalid = 0, s_bvalid = 0;
  bit ifu_ar = 0, ifu_rw = 0, lsu_ar = 0, lsu_rw = 0, lsu_aw = 0, lsu_w = 0, lsu_bw = 0;
  logic [31:0] ifu_addr = '0, lsu_raddr = '0, lsu_waddr = '0, s_raddr = '0;
  logic [63:0] lsu_wdata = '0;
  logic [7:0]  lsu_wstrb = '0;
  bit rnd_req = 0, use_fix = 0, saw_wvalid_after = 0;
  int rdy_p = 100, ar_p = 100, aw_p = 100, w_p = 100, rv_p = 100, bv_p = 100, aw_delay = 0, aw_wait = 0;
  logic [63:0] fix_rdata = '0, last_ifu_rdata = '0;
  logic [1:0]  fix_rresp = '0, last_ifu_rresp = '0, last_bresp = '0;
  int t_ifu_ar = -1, t_ifu_r = -1, t_lsu_r = -1, t_aw = -1, t_w = -1, t_b = -1, t_m_ar_rise = -1;

  function automatic bit pct(int p);
    return int'($urandom_range(99)) < p;
  endfunction

  // Slave behaviour: read data/resp derive from the address unless a fixed value is requested.
  function automatic logic [63:0] rd_data(logic [31:0] a);
    return use_fix ? fix_rdata : {a, ~a};
  endfunction
  function automatic logic [1:0] rd_resp(logic [31:0] a);
    return use_fix ? fix_rresp : a[5:4];
  endfunction

  function automatic bit busy();
    return ifu_ar || ifu_rw || lsu_ar || lsu_rw || lsu_aw || lsu_w || lsu_bw || own != OWN_NONE;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    own_t own0;
    logic [11:0] e_vec, o_vec;
    bit rd_own, e_m_arvalid, e_m_rready, e_m_awvalid, e_m_wvalid, e_m_bready;
    own0 = own;
    ifu_bus.arvalid = ifu_ar;
    ifu_bus.araddr  = ifu_addr;
    ifu_bus.rready  = ifu_rw && pct(rdy_p);
    lsu_bus.arvalid = lsu_ar;
    lsu_bus.araddr  = lsu_raddr;
    lsu_bus.rready  = lsu_rw && pct(rdy_p);
    lsu_bus.awvalid = lsu_aw;
    lsu_bus.awaddr  = lsu_waddr;
    lsu_bus.wvalid  = lsu_w;
    lsu_bus.wdata   = lsu_wdata;
    lsu_bus.wstrb   = lsu_wstrb;
    lsu_bus.bready  = lsu_bw && pct(rdy_p);
    m_bus.arready   = pct(ar_p);
    m_bus.awready   = pct(aw_p) && aw_wait >= aw_delay;
    m_bus.wready    = pct(w_p);
    if (ar_done && !s_rvalid && pct(rv_p)) s_rvalid = 1;
    if (aw_done_m && w_done_m && !s_bvalid && pct(bv_p)) s_bvalid = 1;
    m_bus.rvalid = s_rvalid;
    m_bus.rdata  = s_rvalid ? rd_data(s_raddr) : {$urandom, $urandom};
    m_bus.rresp  = s_rvalid ? rd_resp(s_raddr) : 2'($urandom);
    m_bus.bvalid = s_bvalid;
    m_bus.bresp  = s_bvalid ? lsu_waddr[5:4] : 2'($urandom);
    #1;
    rd_own      = own0 == OWN_IFU || own0 == OWN_LSU_RD;
    e_m_arvalid = !rst && rd_own && !ar_done && (own0 == OWN_IFU ? ifu_ar : lsu_ar);
    e_m_rready  = !rst && rd_own && ar_done && (own0 == OWN_IFU ? ifu_bus.rready : lsu_bus.rready);
    e_m_awvalid = !rst && own0 == OWN_LSU_WR && !aw_done_m && lsu_aw;
    e_m_wvalid  = !rst && own0 == OWN_LSU_WR && !w_done_m && lsu_w;
    e_m_bready  = !rst && own0 == OWN_LSU_WR && aw_done_m && w_done_m && lsu_bus.bready;
    e_vec = {e_m_arvalid, e_m_rready, e_m_awvalid, e_m_wvalid, e_m_bready,
             !rst && own0 == OWN_IFU && !ar_done && m_bus.arready,
             !rst && own0 == OWN_IFU && ar_done && s_rvalid,
             !rst && own0 == OWN_LSU_RD && !ar_done && m_bus.arready,
             !rst && own0 == OWN_LSU_RD && ar_done && s_rvalid,
             !rst && own0 == OWN_LSU_WR && !aw_done_m && m_bus.awready,
             !rst && own0 == OWN_LSU_WR && !w_done_m && m_bus.wready,
             !rst && own0 == OWN_LSU_WR && aw_done_m && w_done_m && s_bvalid};
    o_vec = {m_bus.arvalid, m_bus.rready, m_bus.awvalid, m_bus.wvalid, m_bus.bready,
             ifu_bus.arready, ifu_bus.rvalid, lsu_bus.arready, lsu_bus.rvalid,
             lsu_bus.awready, lsu_bus.wready, lsu_bus.bvalid};
    chk("valid_ready_vector", 64'(o_vec), 64'(e_vec));
    if (m_bus.arvalid && t_m_ar_rise < 0) t_m_ar_rise = cyc;
    if (rst) begin
      own = OWN_NONE; ar_done = 0; aw_done_m = 0; w_done_m = 0; s_rvalid = 0; s_bvalid = 0;
      ifu_ar = 0; ifu_rw = 0; lsu_ar = 0; lsu_rw = 0; lsu_aw = 0; lsu_w = 0; lsu_bw = 0;
    end else begin
      if (own0 == OWN_LSU_WR && w_done_m && m_bus.wvalid) saw_wvalid_after = 1;
      if (e_m_arvalid && m_bus.arready) begin
        s_raddr = (own0 == OWN_IFU) ? ifu_addr : lsu_raddr;
        chk("m_araddr", 64'(m_bus.araddr), 64'(s_raddr));
        ar_done = 1;
        if (own0 == OWN_IFU) begin ifu_ar = 0; ifu_rw = 1; t_ifu_ar = cyc; end
        else begin lsu_ar = 0; lsu_rw = 1; end
      end
      if (e_m_rready && s_rvalid) begin
        if (own0 == OWN_IFU) begin
          chk("ifu_rdata", ifu_bus.rdata, rd_data(ifu_addr));
          chk("ifu_rresp", 64'(ifu_bus.rresp), 64'(rd_resp(ifu_addr)));
          last_ifu_rdata = ifu_bus.rdata; last_ifu_rresp = ifu_bus.rresp;
          ifu_rw = 0; t_ifu_r = cyc;
        end else begin
          chk("lsu_rdata", lsu_bus.rdata, rd_data(lsu_raddr));
          chk("lsu_rresp", 64'(lsu_bus.rresp), 64'(rd_resp(lsu_raddr)));
          lsu_rw = 0; t_lsu_r = cyc;
        end
        own = OWN_NONE; ar_done = 0; s_rvalid = 0; n_done++;
      end
      if (e_m_bready && s_bvalid) begin
        chk("lsu_bresp", 64'(lsu_bus.bresp), 64'(lsu_waddr[5:4]));
        last_bresp = lsu_bus.bresp;
        own = OWN_NONE; aw_done_m = 0; w_done_m = 0; s_bvalid = 0; lsu_bw = 0; t_b = cyc; n_done++;
      end
      if (e_m_awvalid && m_bus.awready) begin
        chk("m_awaddr", 64'(m_bus.awaddr), 64'(lsu_waddr));
        aw_done_m = 1; lsu_aw = 0; t_aw = cyc;
      end
      if (e_m_wvalid && m_bus.wready) begin
        chk("m_wdata", m_bus.wdata, lsu_wdata);
        chk("m_wstrb", 64'(m_bus.wstrb), 64'(lsu_wstrb));
        w_done_m = 1; lsu_w = 0; t_w = cyc;
      end
      if (own == OWN_LSU_WR && aw_done_m && w_done_m) lsu_bw = 1;
      if (own0 == OWN_LSU_WR && !aw_done_m) aw_wait++;
      // Arbitration decision made on the free cycle takes effect from the following cycle.
      if (own0 == OWN_NONE) begin
        aw_wait = 0;
        if (lsu_aw || lsu_w) own = OWN_LSU_WR;
        else if (lsu_ar)     own = OWN_LSU_RD;
        else if (ifu_ar)     own = OWN_IFU;
      end
      if (rnd_req) begin
        if (!ifu_ar && !ifu_rw && pct(25)) begin
          ifu_ar = 1; ifu_addr = {4'h8, 25'($urandom), 3'b000};
        end
        if (!(lsu_ar || lsu_rw || lsu_aw || lsu_w || lsu_bw) && pct(25)) begin
          if (pct(50)) begin
            lsu_ar = 1; lsu_raddr = {4'h9, 25'($urandom), 3'b000};
          end else begin
            lsu_aw = 1; lsu_w = 1; lsu_waddr = {4'hA, 25'($urandom), 3'b000};
            lsu_wdata = {$urandom, $urandom}; lsu_wstrb = 8'($urandom);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    chk("drain_within_budget", 64'(busy()), 64'(0));
  endtask

  initial begin
    int c0, n0;
    ifu_bus.awaddr = '0; ifu_bus.awvalid = 0; ifu_bus.awready = 0; ifu_bus.wdata = '0;
    ifu_bus.wstrb = '0; ifu_bus.wvalid = 0; ifu_bus.wready = 0; ifu_bus.bresp = '0;
    ifu_bus.bvalid = 0; ifu_bus.bready = 0;
    rst = 1;
    step();
    step();
    chk("reset_state", 64'(dut.state), 64'(ST_IDLE));
    rst = 0;

    use_fix = 1; fix_rdata = 64'h1122334455667788; fix_rresp = RESP_OKAY;
    ifu_ar = 1; ifu_addr = 32'h8000_0000; c0 = cyc;
    step(); step(); step();
    chk("ifu_only_idle_4th_cycle", 64'(dut.state), 64'(ST_IDLE));
    chk("ifu_only_rdata", last_ifu_rdata, 64'h1122334455667788);
    chk("ifu_only_r_cycle", 64'(t_ifu_r - c0), 64'(2));

    fix_rresp = 2'b10;
    ifu_ar = 1; ifu_addr = 32'h8000_0040;
    wait_idle(50);
    chk("rresp_slverr_passthrough", 64'(last_ifu_rresp), 64'(2'b10));
    use_fix = 0;

    t_lsu_r = -1; t_ifu_ar = -1;
    lsu_ar = 1; lsu_raddr = 32'h8000_1000;
    ifu_ar = 1; ifu_addr = 32'h8000_0004;
    wait_idle(50);
    chk("lsu_read_served_first", 64'(t_lsu_r >= 0 && t_lsu_r < t_ifu_ar), 64'(1));
    chk("ifu_ar_gap_after_lsu_r", 64'(t_ifu_ar - t_lsu_r), 64'(2));

    aw_delay = 2; saw_wvalid_after = 0; t_aw = -1; t_w = -1;
    lsu_aw = 1; lsu_w = 1; lsu_waddr = 32'h8000_2000; lsu_wdata = 64'hDEAD_BEEF; lsu_wstrb = 8'h0F;
    wait_idle(50);
    chk("w_before_aw_gap", 64'(t_aw - t_w), 64'(2));
    chk("wvalid_dropped_after_w", 64'(saw_wvalid_after), 64'(0));
    chk("bresp_okay", 64'(last_bresp), 64'(RESP_OKAY));
    chk("write_back_to_idle", 64'(dut.state), 64'(ST_IDLE));
    aw_delay = 0;

    t_b = -1; t_m_ar_rise = -1;
    lsu_aw = 1; lsu_w = 1; lsu_waddr = 32'h8000_3010; lsu_wdata = 64'h0123_4567_89AB_CDEF; lsu_wstrb = 8'hFF;
    lsu_ar = 1; lsu_raddr = 32'h8000_3020;
    wait_idle(50);
    chk("write_before_read", 64'(t_b >= 0 && t_b < t_m_ar_rise), 64'(1));

    rv_p = 0;
    ifu_ar = 1; ifu_addr = 32'h8000_0100;
    step(); step(); step();
    chk("stalled_in_ifu_r", 64'(dut.state), 64'(ST_IFU_R));
    rst = 1;
    step();
    rst = 0;
    chk("reset_abandons_read", 64'(dut.state), 64'(ST_IDLE));
    step();
    rv_p = 100; n0 = n_done;
    ifu_ar = 1; ifu_addr = 32'h8000_0200;
    wait_idle(50);
    chk("read_after_reset_done", 64'(n_done - n0), 64'(1));
    chk("read_after_reset_data", last_ifu_rdata, 64'h8000_0200_7FFF_FDFF);

    rnd_req = 1; rdy_p = 70; ar_p = 60; aw_p = 50; w_p = 50; rv_p = 60; bv_p = 60; n0 = n_done;
    repeat (1500) step();
    rnd_req = 0;
    wait_idle(300);
    chk("random_progress", 64'(n_done - n0 > 40), 64'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
